// File: rtl/eei.sv
// Shared definitions for the memory-bus arbitration slice.
//   XLEN / MEMBUS_DATA_WIDTH : default Membus address and data widths
//   ARB_STARVE_LIMIT         : default fetch starvation guard for the arbiter
//   membus_src_t             : source ID carried in the response-routing FIFO
//   arb_state_t              : arbiter grant FSM states
package eei;

   localparam int XLEN              = 32;
   localparam int MEMBUS_DATA_WIDTH = 64;
   localparam int ARB_STARVE_LIMIT  = 8;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } membus_src_t;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_t;

endpackage

// File: rtl/Membus.sv
// Memory bus bundle: one request channel (valid/ready handshake carrying
// addr, wen, wdata, wmask) and one response channel (rvalid, rdata, no
// back-pressure).
//   master : issues requests, receives responses
//   slave  : accepts requests, returns responses
interface Membus
   import eei::*;
#(
   parameter int ADDR_W = XLEN,
   parameter int DATA_W = MEMBUS_DATA_WIDTH
);

   logic                  valid;
   logic                  ready;
   logic [ADDR_W-1:0]     addr;
   logic                  wen;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wmask;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (output valid, addr, wen, wdata, wmask,
                   input  ready, rvalid, rdata);
   modport slave  (input  valid, addr, wen, wdata, wmask,
                   output ready, rvalid, rdata);

endinterface

// File: rtl/sync_fifo_id.sv
// Small synchronous FIFO for tags/IDs. Any DEPTH >= 1 (pointers wrap
// modulo DEPTH, no power-of-two requirement). Head is readable
// combinationally; a push into a full FIFO is honoured only when a pop
// happens in the same cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : enqueue request and value
//   pop, pop_data     : dequeue request and current head value
//   full, empty, count: occupancy status
module sync_fifo_id #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 1,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // When full, the slot being written is the head being popped; the
   // head is read before the edge so the overwrite is safe.
   assign push_ok  = push && (!full || pop);
   assign pop_ok   = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/membus_id_arbiter.sv
// Shares one downstream Membus between the instruction fetcher (I) and the
// data path (D). Up to DEPTH requests may be in flight; responses come
// back in order and are steered by a FIFO of source IDs.
//   clk, rst     : clock, asynchronous active-high reset
//   i_bus        : instruction requester (read-only; write fields ignored)
//   d_bus        : data requester
//   out          : downstream request port
//   outstanding  : accepted-but-unanswered request count
//   err_orphan   : sticky, set when a response arrives with nothing pending
module membus_id_arbiter
   import eei::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
   parameter int DATA_PRIO    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   Membus.slave                        i_bus,
   Membus.slave                        d_bus,
   Membus.master                       out,
   output logic [$clog2(DEPTH+1)-1:0]  outstanding,
   output logic                        err_orphan
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   arb_state_t   state_q, state_d;
   membus_src_t  sel_q, sel_d;
   membus_src_t  rr_last_q, rr_last_d;
   logic [SC_W-1:0] starve_q, starve_d;
   logic         err_orphan_q, err_orphan_d;

   membus_src_t  win;
   membus_src_t  head;
   logic [0:0]   head_id;
   logic         win_valid;
   logic         starve_full;
   logic         fifo_full;
   logic         fifo_empty;
   logic         can_issue;
   logic         issue;
   logic         grant_ok;
   logic         accept;
   logic         pop;
   logic         orphan;
   logic         unused_i_write;

   // Fetch never writes; its write fields are ignored.
   assign unused_i_write = ^{i_bus.wen, i_bus.wdata, i_bus.wmask};

   assign starve_full = (starve_q == SC_W'(STARVE_LIMIT));

   always_comb begin
      win = sel_q;
      if (state_q == ST_ARB) begin
         if (DATA_PRIO != 0) begin
            win = (d_bus.valid && !(starve_full && i_bus.valid)) ? SRC_D : SRC_I;
         end else if (i_bus.valid && d_bus.valid) begin
            win = (rr_last_q == SRC_I) ? SRC_D : SRC_I;
         end else begin
            win = d_bus.valid ? SRC_D : SRC_I;
         end
      end
   end

   assign win_valid = (win == SRC_D) ? d_bus.valid : i_bus.valid;

   // A response in this cycle frees its slot for a same-cycle issue.
   assign can_issue = !fifo_full || out.rvalid;
   assign issue     = !rst && can_issue && win_valid;
   assign grant_ok  = !rst && out.ready && can_issue;
   assign accept    = issue && out.ready;
   assign pop       = !rst && out.rvalid && !fifo_empty;
   assign orphan    = out.rvalid && fifo_empty;
   assign head      = membus_src_t'(head_id);

   assign out.valid = issue;
   assign out.addr  = (win == SRC_D) ? d_bus.addr  : i_bus.addr;
   assign out.wen   = (win == SRC_D) ? d_bus.wen   : 1'b0;
   assign out.wdata = (win == SRC_D) ? d_bus.wdata : '0;
   assign out.wmask = (win == SRC_D) ? d_bus.wmask : '0;

   assign i_bus.ready  = grant_ok && (win == SRC_I);
   assign d_bus.ready  = grant_ok && (win == SRC_D);
   assign i_bus.rvalid = pop && (head == SRC_I);
   assign d_bus.rvalid = pop && (head == SRC_D);
   assign i_bus.rdata  = out.rdata;
   assign d_bus.rdata  = out.rdata;

   assign outstanding = u_id_fifo.count;
   assign err_orphan  = err_orphan_q;

   sync_fifo_id #(
      .DEPTH (DEPTH),
      .WIDTH (1)
   ) u_id_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (1'(win)),
      .pop       (pop),
      .pop_data  (head_id),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     ()
   );

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      rr_last_d    = rr_last_q;
      starve_d     = starve_q;
      err_orphan_d = err_orphan_q | orphan;
      case (state_q)
         ST_ARB: begin
            if (issue && !out.ready) begin
               state_d = ST_HOLD;
               sel_d   = win;
            end
         end
         ST_HOLD: begin
            // A held requester that withdraws is a protocol error; drop
            // the hold rather than wedge the grant.
            if (accept || !win_valid) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
      if (accept) begin
         rr_last_d = win;
      end
      if (!i_bus.valid || (accept && (win == SRC_I))) begin
         starve_d = '0;
      end else if (!starve_full) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_ARB;
         sel_q        <= SRC_I;
         rr_last_q    <= SRC_I;
         starve_q     <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         rr_last_q    <= rr_last_d;
         starve_q     <= starve_d;
         err_orphan_q <= err_orphan_d;
      end
   end

endmodule

// File: tb/tb_membus_id_arbiter.sv
module tb_membus_id_arbiter;
   import eei::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 8;
   localparam int AW    = XLEN;
   localparam int DW    = MEMBUS_DATA_WIDTH;
   localparam int MW    = DW / 8;
   localparam int SI    = 0;
   localparam int SD    = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   Membus #(.ADDR_W(AW), .DATA_W(DW)) i_bus ();
   Membus #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();
   Membus #(.ADDR_W(AW), .DATA_W(DW)) o_bus ();
   Membus #(.ADDR_W(AW), .DATA_W(DW)) i2 ();
   Membus #(.ADDR_W(AW), .DATA_W(DW)) d2 ();
   Membus #(.ADDR_W(AW), .DATA_W(DW)) o2 ();

   logic [$clog2(DEPTH+1)-1:0] outstanding, outstanding2;
   logic                       err_orphan, err_orphan2;

   membus_id_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DATA_PRIO(1)) dut (
      .clk(clk), .rst(rst), .i_bus(i_bus), .d_bus(d_bus), .out(o_bus),
      .outstanding(outstanding), .err_orphan(err_orphan));

   membus_id_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DATA_PRIO(0)) dut_rr (
      .clk(clk), .rst(rst), .i_bus(i2), .d_bus(d2), .out(o2),
      .outstanding(outstanding2), .err_orphan(err_orphan2));

   int checks = 0;
   int errors = 0;

   // Reference model: pending source IDs in response order, plus the
   // few pieces of history the arbitration rules depend on.
   int q[$];
   int m_starve;
   bit m_hold;
   int m_hold_src;
   bit m_err;

   // Results of the most recent step, for scenario-level checks.
   bit             last_acc;
   int             last_src;
   bit             last_rv_i, last_rv_d;
   logic [AW-1:0]  last_addr;
   int             last_out;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_starve = 0;
      m_hold   = 1'b0;
      m_hold_src = SI;
      m_err    = 1'b0;
   endtask

   task automatic idle_inputs();
      i_bus.valid = 1'b0; i_bus.addr = '0; i_bus.wen = 1'b0; i_bus.wdata = '0; i_bus.wmask = '0;
      d_bus.valid = 1'b0; d_bus.addr = '0; d_bus.wen = 1'b0; d_bus.wdata = '0; d_bus.wmask = '0;
      o_bus.ready = 1'b0; o_bus.rvalid = 1'b0; o_bus.rdata = '0;
      i2.valid = 1'b0; i2.addr = '0; i2.wen = 1'b0; i2.wdata = '0; i2.wmask = '0;
      d2.valid = 1'b0; d2.addr = '0; d2.wen = 1'b0; d2.wdata = '0; d2.wmask = '0;
      o2.ready = 1'b0; o2.rvalid = 1'b0; o2.rdata = '0;
   endtask

   // One cycle on the data-priority arbiter: drive after the falling edge,
   // check against the model, advance the model, wait for the next falling edge.
   task automatic step(input logic iv, input logic [AW-1:0] ia,
                       input logic dv, input logic [AW-1:0] da, input logic dwen,
                       input logic [DW-1:0] dwd, input logic [MW-1:0] dwm,
                       input logic ordy, input logic orv, input logic [DW-1:0] ord);
      int win;
      bit wv, can, ev, acc, pop;
      i_bus.valid = iv; i_bus.addr = ia;
      i_bus.wen = 1'($urandom); i_bus.wdata = {$urandom, $urandom}; i_bus.wmask = MW'($urandom);
      d_bus.valid = dv; d_bus.addr = da; d_bus.wen = dwen; d_bus.wdata = dwd; d_bus.wmask = dwm;
      o_bus.ready = ordy; o_bus.rvalid = orv; o_bus.rdata = ord;
      #1;
      can = (q.size() < DEPTH) || orv;
      if (m_hold) win = m_hold_src;
      else        win = (dv && !(m_starve == LIMIT && iv)) ? SD : SI;
      wv  = (win == SD) ? dv : iv;
      ev  = can && wv;
      acc = ev && ordy;
      pop = orv && (q.size() > 0);
      chk("out_valid",   o_bus.valid,  ev);
      chk("i_ready",     i_bus.ready,  ordy && can && (win == SI));
      chk("d_ready",     d_bus.ready,  ordy && can && (win == SD));
      chk("i_rvalid",    i_bus.rvalid, pop && (q[0] == SI));
      chk("d_rvalid",    d_bus.rvalid, pop && (q[0] == SD));
      chk("outstanding", outstanding,  q.size());
      chk("err_orphan",  err_orphan,   m_err);
      if (ev) begin
         chk("out_addr",  o_bus.addr,  (win == SD) ? da : ia);
         chk("out_wen",   o_bus.wen,   (win == SD) ? dwen : 1'b0);
         chk("out_wdata", o_bus.wdata, (win == SD) ? dwd : '0);
         chk("out_wmask", o_bus.wmask, (win == SD) ? dwm : '0);
      end
      if (orv) begin
         chk("i_rdata", i_bus.rdata, ord);
         chk("d_rdata", d_bus.rdata, ord);
      end
      last_acc  = acc;
      last_src  = win;
      last_rv_i = i_bus.rvalid;
      last_rv_d = d_bus.rvalid;
      last_addr = o_bus.addr;
      last_out  = int'(outstanding);
      if (orv && q.size() == 0) m_err = 1'b1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(win);
      if (m_hold) begin
         if (acc || !wv) m_hold = 1'b0;
      end else if (ev && !ordy) begin
         m_hold = 1'b1;
         m_hold_src = win;
      end
      if (!iv || (acc && win == SI)) m_starve = 0;
      else if (m_starve < LIMIT)     m_starve++;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int n = 0; n < 2 * DEPTH + 2; n++) begin
         if (q.size() == 0) break;
         step(0, '0, 0, '0, 0, '0, '0, 1, 1, {$urandom, $urandom});
      end
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      int rr_exp;
      int rq[$];
      bit ip, dp;
      logic [AW-1:0] ia, da;
      logic dwen;
      logic [DW-1:0] dwd;
      logic [MW-1:0] dwm;

      rst = 1'b1;
      idle_inputs();
      model_reset();
      // Requests and a response pending during reset must all be masked.
      i_bus.valid = 1'b1; d_bus.valid = 1'b1; o_bus.ready = 1'b1; o_bus.rvalid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid",   o_bus.valid,  0);
      chk("rst_i_ready",     i_bus.ready,  0);
      chk("rst_d_ready",     d_bus.ready,  0);
      chk("rst_i_rvalid",    i_bus.rvalid, 0);
      chk("rst_d_rvalid",    d_bus.rvalid, 0);
      chk("rst_outstanding", outstanding,  0);
      chk("rst_err_orphan",  err_orphan,   0);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);

      // Round-robin instance: both requesters always valid, 1-cycle responses.
      rr_exp = SD;  // last grant resets to I, so D goes first
      for (int k = 0; k < 8; k++) begin
         i2.valid = 1'b1; i2.addr = AW'(32'h100 + k);
         d2.valid = 1'b1; d2.addr = AW'(32'h200 + k);
         o2.ready = 1'b1; o2.rvalid = (rq.size() > 0); o2.rdata = DW'(k);
         #1;
         chk("rr_grant_d", d2.ready, rr_exp == SD);
         chk("rr_grant_i", i2.ready, rr_exp == SI);
         chk("rr_addr", o2.addr, (rr_exp == SD) ? AW'(32'h200 + k) : AW'(32'h100 + k));
         if (rq.size() > 0) begin
            chk("rr_i_rvalid", i2.rvalid, rq[0] == SI);
            chk("rr_d_rvalid", d2.rvalid, rq[0] == SD);
            chk("rr_rdata", i2.rdata, DW'(k));
            void'(rq.pop_front());
         end
         rq.push_back(rr_exp);
         rr_exp = (rr_exp == SI) ? SD : SI;
         @(negedge clk);
      end
      i2.valid = 1'b0; d2.valid = 1'b0; o2.rvalid = 1'b1;
      @(negedge clk);
      o2.rvalid = 1'b0;
      chk("rr_orphan", err_orphan2, 0);

      // Data priority with starvation guard: D x8 then I, repeating.
      for (int k = 0; k < 27; k++) begin
         step(1, AW'(32'h1000 + 4 * k), 1, AW'(32'h2000 + 4 * k), k[0],
              {2{32'hA5A50000 + 32'(k)}}, MW'(k * 37), 1, q.size() > 0, {$urandom, $urandom});
         chk("starve_acc", last_acc, 1);
         chk("starve_src", last_src, (k % 9 == 8) ? SI : SD);
      end
      drain();

      // Stall with I presented first; grant must stay on I despite D.
      step(1, 32'h300, 0, 32'h400, 1, 64'h11, 8'h0F, 0, 0, '0);
      chk("hold_addr0", last_addr, 32'h300);
      step(1, 32'h300, 1, 32'h400, 1, 64'h11, 8'h0F, 0, 0, '0);
      chk("hold_addr1", last_addr, 32'h300);
      step(1, 32'h300, 1, 32'h400, 1, 64'h11, 8'h0F, 0, 0, '0);
      chk("hold_addr2", last_addr, 32'h300);
      step(1, 32'h300, 1, 32'h400, 1, 64'h11, 8'h0F, 1, 0, '0);
      chk("hold_i_acc", last_acc, 1);
      chk("hold_i_src", last_src, SI);
      step(0, '0, 1, 32'h400, 1, 64'h11, 8'h0F, 1, 1, 64'hBEEF);
      chk("hold_d_acc", last_acc, 1);
      chk("hold_d_src", last_src, SD);
      drain();

      // FIFO full, responses 4 cycles after acceptance.
      step(0, '0, 1, 32'h500, 0, '0, '0, 1, 0, '0);
      step(0, '0, 1, 32'h508, 0, '0, '0, 1, 0, '0);
      step(0, '0, 1, 32'h510, 0, '0, '0, 1, 0, '0);
      chk("full_stall", last_acc, 0);
      chk("full_count", last_out, 2);
      step(0, '0, 1, 32'h510, 0, '0, '0, 1, 0, '0);
      step(0, '0, 1, 32'h510, 0, '0, '0, 1, 1, 64'h1);
      chk("full_refill_acc", last_acc, 1);
      chk("full_refill_rv", last_rv_d, 1);
      step(0, '0, 0, '0, 0, '0, '0, 1, 1, 64'h2);
      chk("full_count_kept", last_out, 2);
      drain();

      // Randomised traffic; requests stay stable until accepted.
      ip = 0; dp = 0; ia = '0; da = '0; dwen = 0; dwd = '0; dwm = '0;
      for (int k = 0; k < 400; k++) begin
         if (!ip && $urandom_range(0, 2) != 0) begin
            ip = 1; ia = AW'($urandom);
         end
         if (!dp && $urandom_range(0, 2) != 0) begin
            dp = 1; da = AW'($urandom); dwen = 1'($urandom);
            dwd = {$urandom, $urandom}; dwm = MW'($urandom);
         end
         step(ip, ia, dp, da, dwen, dwd, dwm, $urandom_range(0, 3) != 0,
              (q.size() > 0) && ($urandom_range(0, 1) == 1), {$urandom, $urandom});
         if (last_acc) begin
            if (last_src == SI) ip = 0;
            else                dp = 0;
         end
      end
      drain();

      // Response with nothing outstanding.
      step(0, '0, 0, '0, 0, '0, '0, 1, 1, 64'h77);
      chk("orphan_no_i_rv", last_rv_i, 0);
      chk("orphan_no_d_rv", last_rv_d, 0);
      repeat (3) step(0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
      chk("orphan_sticky", err_orphan, 1);

      // Reset with two requests in flight, then a stale response.
      step(1, 32'h600, 0, '0, 0, '0, '0, 1, 0, '0);
      step(0, '0, 1, 32'h700, 0, '0, '0, 1, 0, '0);
      chk("mid_two_out", q.size(), 2);
      i_bus.valid = 1'b1; o_bus.ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", o_bus.valid, 0);
      chk("mid_rst_outstanding", outstanding, 0);
      chk("mid_rst_err", err_orphan, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(0, '0, 0, '0, 0, '0, '0, 1, 1, 64'h99);
      chk("stale_no_i_rv", last_rv_i, 0);
      step(0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
      chk("stale_err", err_orphan, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
